ccff_chain_loader: RTL and testbench

- Configuration-chain sequencer for the FPGA fabric.
- Takes configuration words over a valid/ready stream, serialises them, and shifts exactly CHAIN_LEN bits into the configuration flip-flop chain through ccff_head.
- Gates chain shifting through ccff_clk_en. The chain memories (e.g. the connection-block mux memories) have no enable, so they advance only on prog_clk edges where the external clock gate is open.
- Sits between the bitstream source (secure loader/decryptor) and the head of the fabric ccff chain.

---
 rtl/ccff_chain_loader.sv | 145 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises configuration words into the fabric ccff chain.
// Define CCFF_READBACK_EN to add a CRC-16 signature of the displaced ccff_tail bits.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_clk_en,
  output logic              busy,
  output logic              done,
`ifdef CCFF_READBACK_EN
  output logic [15:0]       readback_crc,
`endif
  output logic              aborted
);

  localparam int BL_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  total_cnt;
  logic [BL_W-1:0]   bits_left;

  logic              last_bit;
  logic              final_bit;
  logic              take;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [31:0]       remain;
  logic [BL_W-1:0]   word_bits;

  assign last_bit  = (state == SHIFT) &&
                     (bits_left == BL_W'(1));
  assign final_bit = last_bit &&
                     (total_cnt == CNT_W'(CHAIN_LEN - 1));

  assign word_ready = (state == LOAD) ||
                      (last_bit && !final_bit);
  assign take = word_ready && word_valid && !abort;

  // Bits still owed once this edge's shift lands.
  assign cnt_nxt = (state == SHIFT) ?
                   total_cnt + CNT_W'(1) : total_cnt;
  assign remain  = 32'(CHAIN_LEN) - 32'(cnt_nxt);
  assign word_bits = (remain >= 32'(WORD_W)) ?
                     BL_W'(WORD_W) : BL_W'(remain);

  assign ccff_clk_en = (state == SHIFT);
  assign ccff_head   = ccff_clk_en & sreg[0];
  assign busy        = (state == LOAD) ||
                       (state == SHIFT);
  assign done        = (state == DONE);

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state     <= IDLE;
      sreg      <= '0;
      total_cnt <= '0;
      bits_left <= '0;
      aborted   <= 1'b0;
    end else begin
      aborted <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            total_cnt <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (take) begin
            sreg      <= word_in;
            bits_left <= word_bits;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          sreg      <= sreg >> 1;
          total_cnt <= cnt_nxt;
          bits_left <= bits_left - BL_W'(1);
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (final_bit) begin
            state <= DONE;
          end else if (last_bit) begin
            if (take) begin
              sreg      <= word_in;
              bits_left <= word_bits;
            end else begin
              state <= LOAD;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic        crc_fb;
  logic [15:0] crc_nxt;

  assign crc_fb  = readback_crc[15] ^ ccff_tail;
  assign crc_nxt = {readback_crc[14:0], 1'b0} ^
                   (crc_fb ? 16'h1021 : 16'h0000);

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      readback_crc <= 16'hFFFF;
    end else if (state == IDLE && start) begin
      readback_crc <= 16'hFFFF;
    end else if (state == SHIFT) begin
      readback_crc <= crc_nxt;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: table and scoreboard bench for ccff_chain_loader.
// Covers CHAIN_LEN 4/20 builds, plus CHAIN_LEN 8 readback when CCFF_READBACK_EN.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // CHAIN_LEN=4 instance
  logic       a_rst_n, a_start, a_abort, a_valid;
  logic [7:0] a_word;
  logic       a_ready, a_head, a_en, a_busy;
  logic       a_done, a_aborted;
  logic       a_tail = 1'b0;

  // CHAIN_LEN=20 instance
  logic       b_rst_n, b_start, b_abort, b_valid;
  logic [7:0] b_word;
  logic       b_ready, b_head, b_en, b_busy;
  logic       b_done, b_aborted;
  logic       b_tail = 1'b0;

`ifdef CCFF_READBACK_EN
  logic [15:0] a_crc_unused, b_crc_unused;
  logic        c_rst_n, c_start, c_valid;
  logic        c_abort = 1'b0;
  logic [7:0]  c_word;
  logic        c_tail;
  logic        c_ready, c_head, c_en, c_busy;
  logic        c_done, c_aborted;
  logic [15:0] c_crc;
`endif

  ccff_chain_loader #(.CHAIN_LEN(4), .WORD_W(8)) u_a (
    .prog_clk    (clk),
    .pReset      (a_rst_n),
    .start       (a_start),
    .abort       (a_abort),
    .word_in     (a_word),
    .word_valid  (a_valid),
    .word_ready  (a_ready),
    .ccff_head   (a_head),
    .ccff_tail   (a_tail),
    .ccff_clk_en (a_en),
    .busy        (a_busy),
    .done        (a_done),
`ifdef CCFF_READBACK_EN
    .readback_crc(a_crc_unused),
`endif
    .aborted     (a_aborted)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_b (
    .prog_clk    (clk),
    .pReset      (b_rst_n),
    .start       (b_start),
    .abort       (b_abort),
    .word_in     (b_word),
    .word_valid  (b_valid),
    .word_ready  (b_ready),
    .ccff_head   (b_head),
    .ccff_tail   (b_tail),
    .ccff_clk_en (b_en),
    .busy        (b_busy),
    .done        (b_done),
`ifdef CCFF_READBACK_EN
    .readback_crc(b_crc_unused),
`endif
    .aborted     (b_aborted)
  );

`ifdef CCFF_READBACK_EN
  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_c (
    .prog_clk    (clk),
    .pReset      (c_rst_n),
    .start       (c_start),
    .abort       (c_abort),
    .word_in     (c_word),
    .word_valid  (c_valid),
    .word_ready  (c_ready),
    .ccff_head   (c_head),
    .ccff_tail   (c_tail),
    .ccff_clk_en (c_en),
    .busy        (c_busy),
    .done        (c_done),
    .readback_crc(c_crc),
    .aborted     (c_aborted)
  );
`endif

  // Scoreboard for the CHAIN_LEN=20 instance
  logic sb[$];
  bit   mon_on = 1'b0;
  int   cyc = 0;
  int   en_cnt, busy_cnt, stall_cnt, hs_cnt;
  int   first_en, last_en, model_total;
  int   nb;
  logic exp_bit;

  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (b_en) begin
        if (en_cnt == 0) first_en = cyc;
        last_en = cyc;
        en_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: shift at cycle %0d with no bit expected",
                   cyc);
        end else begin
          exp_bit = sb.pop_front();
          chk("head_bit", b_head, exp_bit);
        end
      end else begin
        chk("head_zero_when_gated", b_head, 0);
      end
      if (b_busy) busy_cnt++;
      if (b_busy && !b_en) stall_cnt++;
      if (b_ready && b_valid && !b_abort && b_rst_n) begin
        hs_cnt++;
        nb = (20 - model_total > 8) ? 8 : 20 - model_total;
        for (int j = 0; j < nb; j++) sb.push_back(b_word[j]);
        model_total += nb;
      end
    end
  end

  task automatic b_begin;
    en_cnt = 0; busy_cnt = 0; stall_cnt = 0; hs_cnt = 0;
    first_en = 0; last_en = 0; model_total = 0;
    sb.delete();
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    b_valid = 1'b1;
    b_word  = w;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      ok = b_ready;
      tick;
    end
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_done;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = b_done;
    end
    chk("done_seen", ok, 1);
    tick;
  endtask

  task automatic wait_shifts(input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < 60 && seen < n; k++) begin
      @(negedge clk);
      if (b_en) seen++;
    end
    chk("shift_wait", seen, n);
    tick;
  endtask

  task automatic full_load(input string tag);
    b_begin;
    send(8'hA5);
    send(8'h5A);
    send(8'h0C);
    b_valid = 1'b0;
    wait_done;
    chk({tag, "_shifts"}, en_cnt, 20);
    chk({tag, "_hs"}, hs_cnt, 3);
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic       valid;
    logic [7:0] word;
    logic [5:0] exp; // ready,en,head,busy,done,aborted
  } vec_t;

  vec_t tbl[9];

`ifdef CCFF_READBACK_EN
  task automatic c_load(input logic tail, output bit ok);
    c_tail  = tail;
    c_start = 1'b1;
    tick;
    c_start = 1'b0;
    c_valid = 1'b1;
    c_word  = 8'h00;
    tick;
    c_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = c_done;
    end
    tick;
  endtask
`endif

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b000000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h0A, 6'b100100};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'hFF, 6'b010100};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'hFF, 6'b011100};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'hFF, 6'b010100};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'hFF, 6'b011100};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 8'hFF, 6'b000010};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'hFF, 6'b000000};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b000000};

    a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0;
    a_valid = 1'b0; a_word = 8'h00;
    b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    b_valid = 1'b0; b_word = 8'h00;
`ifdef CCFF_READBACK_EN
    c_rst_n = 1'b0; c_start = 1'b0; c_valid = 1'b0;
    c_word = 8'h00; c_tail = 1'b0;
`endif
    tick;
    tick;
    @(negedge clk);
    chk("reset_a", {a_ready, a_en, a_head, a_busy,
                    a_done, a_aborted}, 0);
    chk("reset_b", {b_ready, b_en, b_head, b_busy,
                    b_done, b_aborted}, 0);
    tick;
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
`ifdef CCFF_READBACK_EN
    c_rst_n = 1'b1;
`endif
    mon_on = 1'b1;

    // Single short word into a 4-bit chain
    for (int i = 0; i < 9; i++) begin
      a_start = tbl[i].start;
      a_abort = tbl[i].abort;
      a_valid = tbl[i].valid;
      a_word  = tbl[i].word;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {a_ready, a_en, a_head, a_busy,
           a_done, a_aborted}, tbl[i].exp);
      tick;
    end

    // Gap-free streaming, extra word offered after the final one
    b_begin;
    send(8'hFF);
    send(8'h00);
    send(8'h05);
    b_word = 8'hEE;
    wait_done;
    b_valid = 1'b0;
    chk("stream_shifts", en_cnt, 20);
    chk("stream_span", last_en - first_en + 1, 20);
    chk("stream_hs", hs_cnt, 3);
    chk("stream_busy", busy_cnt, 21);
    chk("stream_sb_empty", sb.size(), 0);

    // Source starves for 5 ready cycles between words 1 and 2
    b_begin;
    send(8'h3C);
    b_valid = 1'b0;
    nb = 0;
    for (int k = 0; k < 60 && nb < 5; k++) begin
      @(negedge clk);
      if (b_ready) nb++;
      tick;
    end
    send(8'hA5);
    send(8'h0F);
    b_valid = 1'b0;
    wait_done;
    chk("stall_shifts", en_cnt, 20);
    chk("stall_gated", stall_cnt, 6);
    chk("stall_span", last_en - first_en + 1, 25);
    chk("stall_busy", busy_cnt, 26);
    chk("stall_hs", hs_cnt, 3);

    // Abort in LOAD beats an offered word
    b_begin;
    b_valid = 1'b1;
    b_word  = 8'h55;
    b_abort = 1'b1;
    @(negedge clk);
    chk("abort_load_ready", b_ready, 1);
    tick;
    b_abort = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    chk("abort_load_after", {b_ready, b_en, b_busy,
                             b_aborted}, 4'b0001);
    chk("abort_load_hs", hs_cnt, 0);
    tick;
    @(negedge clk);
    chk("abort_pulse_len", b_aborted, 0);
    tick;

    // Abort on the 6th shift cycle, then a clean reload
    b_begin;
    send(8'hFF);
    b_valid = 1'b0;
    wait_shifts(5);
    b_abort = 1'b1;
    @(negedge clk);
    tick;
    b_abort = 1'b0;
    @(negedge clk);
    chk("abort_shift_after", {b_ready, b_en, b_head,
                              b_busy, b_aborted}, 5'b00001);
    chk("abort_shift_count", en_cnt, 6);
    tick;
    @(negedge clk);
    chk("abort_shift_pulse", b_aborted, 0);
    tick;
    full_load("reload");

    // Reset mid-shift leaves the loader idle
    b_begin;
    send(8'hFF);
    b_valid = 1'b0;
    wait_shifts(3);
    b_rst_n = 1'b0;
    tick;
    b_rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midreset_outs", {b_ready, b_en, b_head, b_busy,
                          b_done, b_aborted}, 0);
    b_valid = 1'b1;
    b_word  = 8'h77;
    for (int k = 0; k < 3; k++) begin
      tick;
      @(negedge clk);
      chk("midreset_idle", {b_ready, b_busy}, 0);
    end
    tick;
    b_valid = 1'b0;
    full_load("resume");

`ifdef CCFF_READBACK_EN
    begin
      bit ok;
      logic [15:0] crc0;
      c_load(1'b0, ok);
      chk("crc0_done", ok, 1);
      crc0 = c_crc;
      chk("crc_tail0", crc0, 16'hE1F0);
      tick;
      chk("crc_hold", c_crc, crc0);
      c_load(1'b1, ok);
      chk("crc1_done", ok, 1);
      chk("crc_tail1_differs", c_crc != 16'hE1F0, 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
